// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time over valid/ready,
// waits LATENCY cycles, performs the byte/half/word access and holds the
// response until the core takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Once valid is raised, the payload stays stable until that edge.
// req_ready is 1 only in IDLE. resp_valid is 1 only in RESP, and the
// response stays stable until resp_ready is seen.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT4       = 4'(LATENCY);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_funct3;

  logic [31:0] mem [DEPTH_WORDS];

  logic          access_now;
  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          acc_err;
  logic [31:0]   load_data;
  logic [31:0]   store_word;
  logic          do_write;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // The access is performed on the edge that leaves WAIT.
  assign access_now = (state == ST_WAIT) && (cnt == 4'd0);
  assign in_range   = ({1'b0, lat_addr} < ADDR_LIMIT);
  assign widx       = lat_addr[AW+1:2];
  assign rword      = mem[widx];
  assign byte_sel   = rword[{lat_addr[1:0], 3'b000} +: 8];
  assign half_sel   = rword[{lat_addr[1], 4'b0000} +: 16];
  assign do_write   = access_now && lat_write && !acc_err && !rst;

  // Decode the latched request: error check, load extension, store merge.
  always_comb begin
    acc_err    = 1'b0;
    load_data  = 32'h0;
    store_word = rword;
    if (lat_write) begin
      case (lat_funct3)
        3'b000: store_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
        3'b001: begin
          if (lat_addr[0]) acc_err = 1'b1;
          else store_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
        end
        3'b010: begin
          if (lat_addr[1:0] != 2'b00) acc_err = 1'b1;
          else store_word = lat_wdata;
        end
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (lat_funct3)
        3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
        3'b100: load_data = {24'h0, byte_sel};
        3'b001: begin
          if (lat_addr[0]) acc_err = 1'b1;
          else load_data = {{16{half_sel[15]}}, half_sel};
        end
        3'b101: begin
          if (lat_addr[0]) acc_err = 1'b1;
          else load_data = {16'h0, half_sel};
        end
        3'b010: begin
          if (lat_addr[1:0] != 2'b00) acc_err = 1'b1;
          else load_data = rword;
        end
        default: acc_err = 1'b1;
      endcase
    end
    if (!in_range) acc_err = 1'b1;
    if (acc_err || lat_write) load_data = 32'h0;
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem[widx] <= store_word;
  end

  // Control FSM, request latch and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_funct3 <= 3'b000;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            cnt        <= LAT4;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= acc_err;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data-memory port: receives load/store requests from the core over a valid/ready handshake, inserts programmable wait states, performs byte/half/word accesses, and returns a response.
- Replaces the zero-wait data memory so the core's load/store path can be exercised against a slow, handshaked memory.
- One outstanding request at a time.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; byte address range 0 .. 4*DEPTH_WORDS-1.
- LATENCY, 2, wait-state cycles inserted between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low bytes are used for sb/sh.
- req_funct3  input  3  RISC-V funct3 of the load/store instruction.
- resp_valid  output  1  response available.
- resp_ready  input  1  core accepts the response.
- resp_rdata  output  32  load data, already extended; 0 for stores and for errors.
- resp_err  output  1  request was rejected (misaligned, out of range, or illegal funct3).

Behaviour:
- Reset (async, on rst=1): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- Reset does not clear memory contents.
- States:
  - IDLE: req_ready=1. When req_valid=1, latch write, addr, wdata and funct3 at the clock edge, load counter with LATENCY, go to WAIT.
  - WAIT: req_ready=0. While counter!=0, decrement it. When counter==0, perform the access at that edge, register resp_rdata/resp_err, go to RESP.
  - RESP: req_ready=0, resp_valid=1, resp_rdata/resp_err held stable. When resp_ready=1, go to IDLE at that edge (resp_valid=0, resp_rdata=0, resp_err=0).
- Latency: resp_valid rises LATENCY+1 cycles after the accepting edge (LATENCY=0 gives 1 cycle).
- A new request is accepted no earlier than the cycle after the response handshake; there is no same-cycle turnaround.
- Loads:
  - funct3 000 lb and 001 lh sign-extend; 100 lbu and 101 lhu zero-extend; 010 lw returns the full word.
  - Byte lane is addr[1:0]; half lane is addr[1]; little-endian.
- Stores:
  - funct3 000 sb, 001 sh, 010 sw.
  - Only the addressed bytes change.
  - The write commits only at the WAIT-to-RESP edge.
- Error conditions. resp_err=1, no memory change, resp_rdata=0:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= 4*DEPTH_WORDS;
  - any other funct3 (011, 110, 111, or 100/101 on a store).
- Word index is addr[31:2] after the range check; no wrap-around.
- Reset mid-operation: a request in WAIT is dropped with no write; a pending response in RESP is discarded.
- Inputs are ignored outside IDLE. A req_valid held high across a response is accepted again only after returning to IDLE.

Test Plan:
- Store then load word: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid rises 3 cycles after each accept (LATENCY=2).
- Byte/half extension: sw 0x20 with 0x80FF7F01; lb 0x23 -> 0xFFFFFF80; lbu 0x23 -> 0x00000080; lh 0x20 -> 0x00007F01; lhu 0x22 -> 0x000080FF.
- Partial store: sw 0x30 with 0x11223344, then sb 0x31 with 0x000000AA -> lw 0x30 returns 0x1122AA44; then sh 0x32 with 0x0000BEEF -> lw 0x30 returns 0xBEEFAA44.
- Errors: lw 0x12, sh 0x31, lw 0x400 (DEPTH_WORDS=256), and funct3=011 -> resp_err=1, resp_rdata=0; a following lw 0x10 still returns 0xDEADBEEF.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0; raise resp_ready -> IDLE next edge, req_ready=1.
- Reset mid-op: accept sw 0x40 with 0x12345678, assert rst during WAIT -> outputs return to reset values immediately; after release, lw 0x40 returns its pre-request value.
